// File: rtl/pwm_pkg.sv
// Shared constants for the PWM block: default counter width and the
// encoding of the count-direction input.
package pwm_pkg;

    localparam int   DEFAULT_WIDTH = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pwm_counter.sv
// Up/down auto-reload counter. Exposes its next-state value so the parent can
// register a compare result on the same edge the count itself advances.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] arr_i,
    output logic [WIDTH-1:0] cnt_d_o
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Increment only below ARR and decrement only above zero, so the
    // arithmetic can never wrap; an out-of-range count reloads instead.
    always_comb begin
        cnt_d = cnt_q;
        if (dir_i == DIR_UP) begin
            if (cnt_q >= arr_i) begin
                cnt_d = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            if ((cnt_q == ZERO) || (cnt_q > arr_i)) begin
                cnt_d = arr_i;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/pwm.sv
// Edge-aligned PWM generator: ARR sets the period, CCR sets the duty, and dir
// selects counting up (high at the start of the period) or down.
module pwm
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic [WIDTH-1:0] ARR,
    input  logic [WIDTH-1:0] CCR,
    output logic             wave
);

    logic [WIDTH-1:0] cnt_d;
    logic             wave_q;
    logic             wave_d;

    pwm_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .dir_i   (dir),
        .arr_i   (ARR),
        .cnt_d_o (cnt_d)
    );

    // Compare against the upcoming count so wave lines up with the count
    // value it is registered alongside.
    always_comb begin
        wave_d = 1'b0;
        if (dir == DIR_UP) begin
            wave_d = (cnt_d <= CCR);
        end else begin
            wave_d = (cnt_d >= CCR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_q <= 1'b0;
        end else begin
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: directed duty/period scenarios followed by a
// randomized run, all checked cycle by cycle against a behavioural model.
module tb_pwm;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         dir;
    logic [W-1:0] ARR;
    logic [W-1:0] CCR;
    logic         wave;

    always #5 clk = ~clk;

    pwm #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dir  (dir),
        .ARR  (ARR),
        .CCR  (CCR),
        .wave (wave)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_cnt = 0;
    logic m_wave = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int dut_cnt();
        return int'(dut.u_counter.cnt_q);
    endfunction

    // Reference: the counter rules and compare rules stated directly in integers.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (dir) begin
            m_cnt = (m_cnt >= int'(ARR)) ? 0 : m_cnt + 1;
        end else begin
            m_cnt = (m_cnt == 0 || m_cnt > int'(ARR)) ? int'(ARR) : m_cnt - 1;
        end
        m_wave = dir ? (m_cnt <= int'(CCR)) : (m_cnt >= int'(CCR));
        #1;
        check_bit("wave", wave, m_wave);
        check_int("cnt", dut_cnt(), m_cnt);
    endtask

    task automatic run(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            tick();
            highs += int'(wave);
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_async_wave", wave, 1'b0);
        check_int("rst_async_cnt", dut_cnt(), 0);
        @(posedge clk);
        #1;
        check_bit("rst_hold_wave", wave, 1'b0);
        check_int("rst_hold_cnt", dut_cnt(), 0);
        rst    = 1'b0;
        m_cnt  = 0;
        m_wave = 1'b0;
    endtask

    task automatic cfg(input logic d, input int a, input int c);
        dir = d;
        ARR = W'(a);
        CCR = W'(c);
    endtask

    task automatic duty(input string tag, input logic d, input int a, input int c,
                        input int exp_high);
        int highs;
        int start_cnt;
        cfg(d, a, c);
        tick();
        start_cnt = dut_cnt();
        run(a + 1, highs);
        check_int({tag, "_high"}, highs, exp_high);
        check_int({tag, "_period"}, dut_cnt(), start_cnt);
        $display("step %s: dir=%0d ARR=%0d CCR=%0d high=%0d/%0d", tag, d, a, c, highs, a + 1);
    endtask

    initial begin
        int found;
        int highs;

        rst = 1'b1;
        cfg(1'b1, 999, 99);
        #1;
        check_bit("reset_wave", wave, 1'b0);
        check_int("reset_cnt", dut_cnt(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tick();
        check_int("first_cnt_up", dut_cnt(), 1);
        $display("step start: first post-reset count=%0d", dut_cnt());

        duty("up_ccr99",    1'b1, 999, 99,  100);
        duty("down_ccr99",  1'b0, 999, 99,  901);
        duty("up_ccr499",   1'b1, 999, 499, 500);
        duty("down_ccr499", 1'b0, 999, 499, 501);

        // Full-on boundaries straight out of reset.
        do_reset();
        duty("up_ccr_eq_arr", 1'b1, 999, 999, 1000);
        do_reset();
        duty("down_ccr0", 1'b0, 999, 0, 1000);
        duty("down_ccr_gt_arr", 1'b0, 999, 1200, 0);
        duty("up_ccr_gt_arr", 1'b1, 999, 5000, 1000);

        // ARR=0 pins the count.
        cfg(1'b1, 0, 7);
        run(5, highs);
        check_int("arr0_up_cnt", dut_cnt(), 0);
        check_int("arr0_up_high", highs, 5);
        cfg(1'b0, 0, 7);
        run(5, highs);
        check_int("arr0_down_high", highs, 0);
        cfg(1'b0, 0, 0);
        run(5, highs);
        check_int("arr0_down_ccr0_high", highs, 5);
        $display("step arr0: cnt=%0d", dut_cnt());

        // Lowering ARR below the count forces a wrap.
        do_reset();
        cfg(1'b1, 999, 300);
        run(700, highs);
        ARR = W'(100);
        tick();
        check_int("arr_lower_up_wrap", dut_cnt(), 0);
        cfg(1'b0, 999, 300);
        run(200, highs);
        ARR = W'(50);
        tick();
        check_int("arr_lower_down_wrap", dut_cnt(), 50);
        $display("step arr_lower: down wrap cnt=%0d", dut_cnt());

        // Direction toggles at cnt=500 continue without reload.
        cfg(1'b1, 999, 499);
        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            tick();
            if (m_cnt == 500) found = 1;
        end
        check_int("reach500_up", found, 1);
        dir = 1'b0;
        tick();
        check_int("toggle_to_down", dut_cnt(), 499);
        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            tick();
            if (m_cnt == 500) found = 1;
        end
        check_int("reach500_down", found, 1);
        dir = 1'b1;
        tick();
        check_int("toggle_to_up", dut_cnt(), 501);
        $display("step dir_toggle: cnt=%0d", dut_cnt());

        // Reset mid-count in down mode.
        cfg(1'b0, 999, 0);
        run(37, highs);
        do_reset();
        tick();
        $display("step midreset: cnt after release=%0d", dut_cnt());

        // Randomized live changes of ARR/CCR/dir with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 15) == 0) begin
                    ARR = 16'hFFFF;
                    CCR = W'($urandom_range(65530, 65535));
                end else begin
                    ARR = W'($urandom_range(0, 40));
                    CCR = W'($urandom_range(0, 45));
                end
                dir = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            tick();
        end
        $display("step random: cycles=%0d compared=%0d", cyc, n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
